lsu_queue: RTL and testbench
============================

LSU_QUEUE -- requirements
Module: lsu_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-order request queue entries (power of two, >=2).
REQ-002 SHALL have parameter ROB_W, default 5, ROB index width.
REQ-003 SHALL have parameter PREG_W, default 6, physical register tag width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush, input, 1, synchronous pipeline flush.
REQ-007 SHALL have port valid_in, input, 1, request present.
REQ-008 SHALL have port addr, input, 32, byte address.
REQ-009 SHALL have port wdata, input, 32, store data (LSB-justified).
REQ-010 SHALL have port mem_op, input, 3, funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port mem_is_load, input, 1, 1 = load, 0 = store.
REQ-012 SHALL have ports rob_idx_in (ROB_W), rd_tag_in (PREG_W), rd_is_fp_in (1), inputs, carried tags.
REQ-013 SHALL have port full, output, 1, queue holds DEPTH entries; valid_in ignored while high.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-015 SHALL have ports wb_valid (1), wb_value (32), wb_rob_idx (ROB_W), wb_dest_tag (PREG_W), wb_dest_is_fp (1), wb_exception (1), outputs, registered writeback.
REQ-016 SHALL have ports mem_req (1), mem_we (1), mem_addr (32, word-aligned), mem_wdata (32), mem_wstrb (4), outputs, memory request.
REQ-017 SHALL have ports mem_rdata (32), mem_ready (1), inputs; mem_ready high in a cycle with mem_req completes the transfer, mem_rdata valid that same cycle.

Function
REQ-018 Enqueue SHALL occur when valid_in && !full; full blocks enqueue even if the head retires that cycle.
REQ-019 Misalignment SHALL be computed at enqueue (W: addr[1:0]!=0; H/HU: addr[0]) and stored as an exception bit in the entry.
REQ-020 Entries SHALL be processed strictly in FIFO order; head/tail pointers wrap modulo DEPTH.
REQ-021 Head FSM states SHALL be IDLE, MEM, WB.
REQ-022 IDLE -> MEM when queue non-empty and head entry not excepted; IDLE -> WB when head excepted.
REQ-023 In MEM, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata/mem_wstrb SHALL stay stable until mem_ready; MEM -> WB on mem_ready.
REQ-024 WB SHALL assert wb_valid for exactly one cycle, pop the head, return to IDLE.
REQ-025 mem_wstrb SHALL be 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W), 0000 for loads; mem_wdata SHALL replicate byte x4 / half x2 / word.
REQ-026 Load data SHALL be captured on mem_ready, byte/half selected by addr[1:0]/addr[1], sign-extended for B/H, zero-extended for BU/HU.
REQ-027 wb_value SHALL be 0 for stores and excepted entries; wb_exception SHALL equal the entry exception bit.
REQ-028 Latency: enqueue into empty queue at cycle N -> mem_req at N+1; mem_ready at cycle M -> wb_valid at M+1; excepted head -> wb_valid two cycles after reaching head, no mem_req.
REQ-029 Throughput SHALL be one retirement per 3 cycles minimum with zero-wait memory.
REQ-030 flush SHALL empty the queue, force FSM to IDLE, clear wb_valid next cycle, and drop mem_req next cycle; a same-cycle valid_in SHALL be discarded.
REQ-031 count SHALL increment on enqueue, decrement on pop, unchanged on simultaneous both.

Reset
REQ-032 rst_n low SHALL immediately clear pointers, count, FSM (IDLE), mem_req, mem_we, mem_wstrb, and all wb_* outputs to 0.
REQ-033 Reset mid-transaction SHALL abandon the request with no writeback after release.

Verification
REQ-034 LW addr 0x100, mem_rdata 0xDEADBEEF, ready 1 cycle later -> wb_valid one cycle, wb_value 0xDEADBEEF, wb_exception 0.
REQ-035 LB addr 0x103, mem_rdata 0x80FF0000 -> wb_value 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
REQ-036 SB addr 0x101 wdata 0x12 -> mem_we 1, mem_addr 0x100, mem_wstrb 0010, mem_wdata 0x12121212, wb_value 0.
REQ-037 Fill DEPTH entries with mem_ready held low -> full 1, count DEPTH, extra valid_in dropped; release ready -> DEPTH writebacks in enqueue ROB order.
REQ-038 LW addr 0x102 -> no mem_req, wb_exception 1, wb_value 0.
REQ-039 flush while MEM with 3 entries queued -> mem_req 0 and count 0 next cycle, no wb_valid afterwards.

Source files
------------

// File: rtl/lsu_queue_if.sv
// lsu_queue_if -- bundles the request, writeback and memory-bus signals of
// the load/store queue.
//   request in : valid_in, addr, wdata, mem_op, mem_is_load,
//                rob_idx_in, rd_tag_in, rd_is_fp_in, full, count
//   writeback  : wb_valid, wb_value, wb_rob_idx, wb_dest_tag,
//                wb_dest_is_fp, wb_exception
//   memory     : mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
//                mem_rdata, mem_ready
// modport slave is the queue itself; modport master is whoever drives
// requests and models the memory.
interface lsu_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 6
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              valid_in;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [2:0]        mem_op;
  logic              mem_is_load;
  logic [ROB_W-1:0]  rob_idx_in;
  logic [PREG_W-1:0] rd_tag_in;
  logic              rd_is_fp_in;
  logic              full;
  logic [CNT_W-1:0]  count;

  logic              wb_valid;
  logic [31:0]       wb_value;
  logic [ROB_W-1:0]  wb_rob_idx;
  logic [PREG_W-1:0] wb_dest_tag;
  logic              wb_dest_is_fp;
  logic              wb_exception;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport slave (
    input  valid_in, addr, wdata, mem_op, mem_is_load,
           rob_idx_in, rd_tag_in, rd_is_fp_in,
    output full, count,
    output wb_valid, wb_value, wb_rob_idx, wb_dest_tag, wb_dest_is_fp,
           wb_exception,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport master (
    output valid_in, addr, wdata, mem_op, mem_is_load,
           rob_idx_in, rd_tag_in, rd_is_fp_in,
    input  full, count,
    input  wb_valid, wb_value, wb_rob_idx, wb_dest_tag, wb_dest_is_fp,
           wb_exception,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/lsu_queue.sv
// lsu_queue -- in-order load/store queue. Requests are buffered in a DEPTH
// entry FIFO; a head FSM issues one memory transfer per entry, formats the
// load result and produces a registered one-cycle writeback.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   flush  synchronous flush: empties the queue and abandons the head
//   bus    lsu_queue_if.slave (request, writeback and memory signals)
//
// state | meaning
// IDLE  | waiting for a head entry (or one arriving into an empty queue)
// MEM   | memory request for the head entry outstanding until mem_ready
// WB    | wb_valid high this cycle; head is popped at the end of it
module lsu_queue #(
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  lsu_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]       ent_addr_q  [DEPTH];
  logic [31:0]       ent_wdata_q [DEPTH];
  logic [2:0]        ent_op_q    [DEPTH];
  logic              ent_ld_q    [DEPTH];
  logic [ROB_W-1:0]  ent_rob_q   [DEPTH];
  logic [PREG_W-1:0] ent_tag_q   [DEPTH];
  logic              ent_fp_q    [DEPTH];
  logic              ent_exc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic full, enq, pop, in_exc, in_mem;

  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_value_q, wb_value_d;
  logic [ROB_W-1:0]  wb_rob_q,   wb_rob_d;
  logic [PREG_W-1:0] wb_tag_q,   wb_tag_d;
  logic              wb_fp_q,    wb_fp_d;
  logic              wb_exc_q,   wb_exc_d;

  logic [31:0]       h_addr, h_wdata;
  logic [2:0]        h_op;
  logic              h_ld, h_fp, h_exc;
  logic [ROB_W-1:0]  h_rob;
  logic [PREG_W-1:0] h_tag;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  // sz is funct3[1:0]: 00 byte, 01 half, otherwise word
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    if (sz[1])      m = (a != 2'b00);
    else if (sz[0]) m = a[0];
    else            m = 1'b0;
    return m;
  endfunction

  // full blocks enqueue even when the head pops this same cycle
  assign full   = (count_q == CNT_W'(DEPTH));
  assign enq    = bus.valid_in && !full && !flush;
  assign in_exc = misaligned(bus.mem_op[1:0], bus.addr[1:0]);

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr_q[tail_q]  <= bus.addr;
      ent_wdata_q[tail_q] <= bus.wdata;
      ent_op_q[tail_q]    <= bus.mem_op;
      ent_ld_q[tail_q]    <= bus.mem_is_load;
      ent_rob_q[tail_q]   <= bus.rob_idx_in;
      ent_tag_q[tail_q]   <= bus.rd_tag_in;
      ent_fp_q[tail_q]    <= bus.rd_is_fp_in;
      ent_exc_q[tail_q]   <= in_exc;
    end
  end

  assign h_addr  = ent_addr_q[head_q];
  assign h_wdata = ent_wdata_q[head_q];
  assign h_op    = ent_op_q[head_q];
  assign h_ld    = ent_ld_q[head_q];
  assign h_rob   = ent_rob_q[head_q];
  assign h_tag   = ent_tag_q[head_q];
  assign h_fp    = ent_fp_q[head_q];
  assign h_exc   = ent_exc_q[head_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (pop) head_q <= head_q + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // load result formatting from the returned word
  always_comb begin
    case (h_addr[1:0])
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = h_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (h_op)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h000000, ld_byte};
      3'b101:  ld_val = {16'h0000, ld_half};
      default: ld_val = bus.mem_rdata;
    endcase
  end

  // store lane replication and byte enables
  always_comb begin
    case (h_op[1:0])
      2'b00: begin
        st_strb = 4'b0001 << h_addr[1:0];
        st_data = {4{h_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << h_addr[1:0];
        st_data = {2{h_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = h_wdata;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    wb_valid_d = 1'b0;
    wb_value_d = wb_value_q;
    wb_rob_d   = wb_rob_q;
    wb_tag_d   = wb_tag_q;
    wb_fp_d    = wb_fp_q;
    wb_exc_d   = wb_exc_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          if (h_exc) begin
            state_d    = WB;
            wb_valid_d = 1'b1;
            wb_value_d = '0;
            wb_exc_d   = 1'b1;
            wb_rob_d   = h_rob;
            wb_tag_d   = h_tag;
            wb_fp_d    = h_fp;
          end else begin
            state_d = MEM;
          end
        end else if (enq && !in_exc) begin
          // bypass: a clean request into an empty queue issues next cycle
          state_d = MEM;
        end
      end
      MEM: begin
        if (bus.mem_ready) begin
          state_d    = WB;
          wb_valid_d = 1'b1;
          wb_value_d = h_ld ? ld_val : '0;
          wb_exc_d   = 1'b0;
          wb_rob_d   = h_rob;
          wb_tag_d   = h_tag;
          wb_fp_d    = h_fp;
        end
      end
      WB: begin
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = IDLE;
      wb_valid_d = 1'b0;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_value_q <= '0;
      wb_rob_q   <= '0;
      wb_tag_q   <= '0;
      wb_fp_q    <= 1'b0;
      wb_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_value_q <= wb_value_d;
      wb_rob_q   <= wb_rob_d;
      wb_tag_q   <= wb_tag_d;
      wb_fp_q    <= wb_fp_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

  assign in_mem = (state_q == MEM);

  assign bus.full          = full;
  assign bus.count         = count_q;
  assign bus.mem_req       = in_mem;
  assign bus.mem_we        = in_mem && !h_ld;
  assign bus.mem_addr      = in_mem ? {h_addr[31:2], 2'b00} : '0;
  assign bus.mem_wdata     = (in_mem && !h_ld) ? st_data : '0;
  assign bus.mem_wstrb     = (in_mem && !h_ld) ? st_strb : '0;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_value      = wb_value_q;
  assign bus.wb_rob_idx    = wb_rob_q;
  assign bus.wb_dest_tag   = wb_tag_q;
  assign bus.wb_dest_is_fp = wb_fp_q;
  assign bus.wb_exception  = wb_exc_q;
endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue -- directed checks of the lsu_queue examples followed by a
// randomized phase scored against a cycle-level reference model.
module tb_lsu_queue;
  localparam int DEPTH  = 4;
  localparam int ROB_W  = 5;
  localparam int PREG_W = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  lsu_queue_if #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W)) bus ();

  lsu_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int rob_ctr = 0;

  typedef struct {
    logic [2:0]        op;
    logic              ld;
    logic [31:0]       a;
    logic [31:0]       wd;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] tag;
    logic              fp;
    logic              exc;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // reference arithmetic derived directly from the access size
  function automatic int f_size(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic f_misal(input logic [2:0] op, input logic [31:0] a);
    return (int'(a[1:0]) % f_size(op)) != 0;
  endfunction

  function automatic logic [3:0] f_strb(input logic [2:0] op, input logic [31:0] a);
    int m;
    m = ((1 << f_size(op)) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] wd);
    int s;
    s = f_size(op);
    if (s == 1) return {4{wd[7:0]}};
    if (s == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * int'(a[1:0]));
    case (op)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic drive_req(input logic v, input logic [2:0] op, input logic ld,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [ROB_W-1:0] rob, input logic [PREG_W-1:0] tag,
                           input logic fp);
    bus.valid_in    = v;
    bus.mem_op      = op;
    bus.mem_is_load = ld;
    bus.addr        = a;
    bus.wdata       = wd;
    bus.rob_idx_in  = rob;
    bus.rd_tag_in   = tag;
    bus.rd_is_fp_in = fp;
  endtask

  // one request into an idle empty queue; dly = cycles of mem_req before mem_ready
  task automatic single(input string tg, input logic [2:0] op, input logic ld,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int dly, input logic [31:0] e_val, input logic e_exc,
                        input logic [31:0] e_addr, input logic [3:0] e_strb,
                        input logic [31:0] e_wdata);
    logic [ROB_W-1:0] rob;
    rob = ROB_W'(rob_ctr);
    rob_ctr++;
    step();
    drive_req(1'b1, op, ld, a, wd, rob, PREG_W'(rob_ctr * 3), 1'b0);
    sample();
    chk({tg, "_req_at_enq"}, 32'(bus.mem_req), 32'd0);
    step();
    bus.valid_in = 1'b0;
    if (!e_exc) begin
      for (int i = 0; i <= dly; i++) begin
        if (i == dly) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rd;
        end
        sample();
        chk({tg, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({tg, "_mem_addr"}, bus.mem_addr, e_addr);
        chk({tg, "_mem_we"}, 32'(bus.mem_we), 32'(!ld));
        chk({tg, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'(e_strb));
        if (!ld) chk({tg, "_mem_wdata"}, bus.mem_wdata, e_wdata);
        step();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end else begin
      sample();
      chk({tg, "_no_req"}, 32'(bus.mem_req), 32'd0);
      chk({tg, "_wb_early"}, 32'(bus.wb_valid), 32'd0);
      step();
    end
    sample();
    chk({tg, "_wb_valid"}, 32'(bus.wb_valid), 32'd1);
    chk({tg, "_wb_value"}, bus.wb_value, e_val);
    chk({tg, "_wb_exc"}, 32'(bus.wb_exception), 32'(e_exc));
    chk({tg, "_wb_rob"}, 32'(bus.wb_rob_idx), 32'(rob));
    chk({tg, "_req_in_wb"}, 32'(bus.mem_req), 32'd0);
    step();
    sample();
    chk({tg, "_wb_one_cycle"}, 32'(bus.wb_valid), 32'd0);
    chk({tg, "_count_empty"}, 32'(bus.count), 32'd0);
  endtask

  initial begin
    logic [ROB_W-1:0] seen[$];
    ent_t e, f;
    int hs, wb_due, cyc;
    logic done, from_pop, popped, accept, exp_req, exp_wb, v, fl, rdy;
    logic [31:0] rd, rd_saved, exp_val;

    drive_req(1'b0, 3'b010, 1'b1, 32'h0, 32'h0, '0, '0, 1'b0);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;

    // reset state
    #3;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_value", bus.wb_value, 32'd0);
    chk("rst_wb_exc", 32'(bus.wb_exception), 32'd0);
    chk("rst_wb_rob", 32'(bus.wb_rob_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed examples
    single("lw", 3'b010, 1'b1, 32'h100, 32'h0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0,
           32'h100, 4'b0000, 32'h0);
    single("lb", 3'b000, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 0, 32'hFFFFFF80, 1'b0,
           32'h100, 4'b0000, 32'h0);
    single("lbu", 3'b100, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 2, 32'h00000080, 1'b0,
           32'h100, 4'b0000, 32'h0);
    single("lh", 3'b001, 1'b1, 32'h102, 32'h0, 32'h80FF0000, 0, 32'hFFFF80FF, 1'b0,
           32'h100, 4'b0000, 32'h0);
    single("lhu", 3'b101, 1'b1, 32'h102, 32'h0, 32'h80FF0000, 0, 32'h000080FF, 1'b0,
           32'h100, 4'b0000, 32'h0);
    single("sb", 3'b000, 1'b0, 32'h101, 32'h12, 32'h0, 2, 32'h0, 1'b0,
           32'h100, 4'b0010, 32'h12121212);
    single("sh", 3'b001, 1'b0, 32'h206, 32'hABCD, 32'h0, 0, 32'h0, 1'b0,
           32'h204, 4'b1100, 32'hABCDABCD);
    single("sw", 3'b010, 1'b0, 32'h308, 32'h01234567, 32'h0, 1, 32'h0, 1'b0,
           32'h308, 4'b1111, 32'h01234567);
    single("lw_misal", 3'b010, 1'b1, 32'h102, 32'h0, 32'h0, 0, 32'h0, 1'b1,
           32'h0, 4'b0000, 32'h0);
    single("sh_misal", 3'b001, 1'b0, 32'h101, 32'h55, 32'h0, 0, 32'h0, 1'b1,
           32'h0, 4'b0000, 32'h0);

    // fill to DEPTH with memory stalled, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      step();
      drive_req(1'b1, 3'b010, 1'b1, 32'h200 + 32'(4 * i), 32'h0, ROB_W'(10 + i), '0, 1'b0);
      sample();
      chk("fill_count", 32'(bus.count), 32'(i));
    end
    step();
    drive_req(1'b1, 3'b010, 1'b1, 32'h300, 32'h0, ROB_W'(31), '0, 1'b0);
    sample();
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count_max", 32'(bus.count), 32'(DEPTH));
    step();
    bus.valid_in = 1'b0;
    sample();
    chk("fill_extra_dropped", 32'(bus.count), 32'(DEPTH));
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h11110000;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (bus.wb_valid) begin
        seen.push_back(bus.wb_rob_idx);
        chk("fill_wb_value", bus.wb_value, 32'h11110000);
      end
      step();
    end
    bus.mem_ready = 1'b0;
    chk("fill_wb_total", 32'(seen.size()), 32'(DEPTH));
    for (int i = 0; i < seen.size(); i++) chk("fill_wb_order", 32'(seen[i]), 32'(10 + i));
    sample();
    chk("fill_drained", 32'(bus.count), 32'd0);

    // flush while MEM with three entries queued
    for (int i = 0; i < 3; i++) begin
      step();
      drive_req(1'b1, 3'b010, 1'b1, 32'h400 + 32'(4 * i), 32'h0, ROB_W'(20 + i), '0, 1'b0);
    end
    step();
    bus.rob_idx_in = ROB_W'(23);
    flush = 1'b1;
    sample();
    chk("flush_pre_req", 32'(bus.mem_req), 32'd1);
    chk("flush_pre_count", 32'(bus.count), 32'd3);
    step();
    flush = 1'b0;
    bus.valid_in = 1'b0;
    sample();
    chk("flush_req_dropped", 32'(bus.mem_req), 32'd0);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_full", 32'(bus.full), 32'd0);
    bus.mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      sample();
      chk("flush_no_wb", 32'(bus.wb_valid), 32'd0);
      chk("flush_no_req", 32'(bus.mem_req), 32'd0);
    end
    bus.mem_ready = 1'b0;

    // reset in the middle of a memory transaction
    step();
    drive_req(1'b1, 3'b010, 1'b1, 32'h500, 32'h0, ROB_W'(7), '0, 1'b0);
    step();
    bus.valid_in = 1'b0;
    #2;
    chk("rstmid_req_before", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_req", 32'(bus.mem_req), 32'd0);
    chk("rstmid_count", 32'(bus.count), 32'd0);
    chk("rstmid_wb", 32'(bus.wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      bus.mem_ready = 1'b1;
      sample();
      chk("rstmid_no_wb", 32'(bus.wb_valid), 32'd0);
      chk("rstmid_no_req", 32'(bus.mem_req), 32'd0);
    end
    bus.mem_ready = 1'b0;

    // randomized phase against the reference model
    q.delete();
    done = 1'b0; from_pop = 1'b0; wb_due = -1; hs = 0; rd_saved = '0;
    for (cyc = 0; cyc < 1500; cyc++) begin
      step();
      v  = ($urandom_range(0, 99) < 55);
      fl = ($urandom_range(0, 99) < 3);
      e.ld = $urandom_range(0, 1);
      if (e.ld) begin
        case ($urandom_range(0, 4))
          0: e.op = 3'b000;
          1: e.op = 3'b001;
          2: e.op = 3'b010;
          3: e.op = 3'b100;
          default: e.op = 3'b101;
        endcase
      end else begin
        e.op = 3'($urandom_range(0, 2));
      end
      e.a = $urandom;
      if ($urandom_range(0, 1) == 1) e.a[1:0] = 2'b00;
      e.wd  = $urandom;
      e.rob = ROB_W'($urandom);
      e.tag = PREG_W'($urandom);
      e.fp  = $urandom_range(0, 1);
      e.exc = f_misal(e.op, e.a);
      rdy = ($urandom_range(0, 99) < 50);
      rd  = $urandom;
      drive_req(v, e.op, e.ld, e.a, e.wd, e.rob, e.tag, e.fp);
      flush = fl;
      bus.mem_ready = rdy;
      bus.mem_rdata = rd;
      sample();

      exp_req = 1'b0;
      exp_wb  = 1'b0;
      if (q.size() != 0) begin
        f = q[0];
        if (f.exc) exp_wb = (cyc == hs + 2);
        else begin
          exp_req = !done && (cyc >= hs + (from_pop ? 2 : 1));
          exp_wb  = done && (cyc == wb_due);
        end
      end
      chk("rnd_count", 32'(bus.count), 32'(q.size()));
      chk("rnd_full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("rnd_mem_req", 32'(bus.mem_req), 32'(exp_req));
      if (exp_req) begin
        chk("rnd_mem_addr", bus.mem_addr, {f.a[31:2], 2'b00});
        chk("rnd_mem_we", 32'(bus.mem_we), 32'(!f.ld));
        chk("rnd_mem_wstrb", 32'(bus.mem_wstrb), f.ld ? 32'd0 : 32'(f_strb(f.op, f.a)));
        if (!f.ld) chk("rnd_mem_wdata", bus.mem_wdata, f_wdata(f.op, f.wd));
      end
      chk("rnd_wb_valid", 32'(bus.wb_valid), 32'(exp_wb));
      if (exp_wb) begin
        exp_val = (f.ld && !f.exc) ? f_load(f.op, f.a, rd_saved) : 32'h0;
        chk("rnd_wb_value", bus.wb_value, exp_val);
        chk("rnd_wb_exc", 32'(bus.wb_exception), 32'(f.exc));
        chk("rnd_wb_rob", 32'(bus.wb_rob_idx), 32'(f.rob));
        chk("rnd_wb_tag", 32'(bus.wb_dest_tag), 32'(f.tag));
        chk("rnd_wb_fp", 32'(bus.wb_dest_is_fp), 32'(f.fp));
      end

      if (fl) begin
        q.delete();
        done = 1'b0;
        wb_due = -1;
      end else begin
        if (exp_req && rdy) begin
          done = 1'b1;
          wb_due = cyc + 1;
          rd_saved = rd;
        end
        accept = v && (q.size() < DEPTH);
        popped = exp_wb;
        if (popped) begin
          void'(q.pop_front());
          done = 1'b0;
          wb_due = -1;
          if (q.size() != 0) begin
            hs = cyc;
            from_pop = 1'b1;
          end
        end
        if (accept) begin
          if (q.size() == 0) begin
            hs = cyc;
            from_pop = popped;
          end
          q.push_back(e);
        end
      end
    end
    flush = 1'b0;
    bus.valid_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
